// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array multiplier output side:
// matrix geometry, controller states and the accumulator narrowing rule.
package systolic_pkg;

  localparam int N      = 4;
  localparam int DATA_W = 8;
  localparam int ACC_W  = 2 * DATA_W + $clog2(N);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    ACCUM = 2'd2,
    HOLD  = 2'd3
  } state_t;

  // Narrow one PE accumulator to an 8-bit element: clamp at 255 when
  // saturating, otherwise keep the low byte (wrap modulo 256).
  function automatic logic [DATA_W-1:0] sat8(input logic [ACC_W-1:0] acc,
                                              input logic             saturate);
    if (saturate && (acc > ACC_W'(255))) begin
      return '1;
    end
    return acc[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/systolic_result_collector.sv
// Output-side controller for the NxN systolic multiplier: clears the PEs,
// runs the feeders for the skew-plus-compute window, captures the narrowed
// accumulators and hands the result matrix over a valid/ready handshake.
module systolic_result_collector
  import systolic_pkg::*;
#(
  parameter int N            = systolic_pkg::N,
  parameter int ACC_W        = systolic_pkg::ACC_W,
  parameter int ACCUM_CYCLES = 3 * systolic_pkg::N - 2,
  parameter int SATURATE     = 1
) (
  input  logic                                  i_clk,
  input  logic                                  i_arst,
  input  logic                                  i_start,
  input  logic [N-1:0][N-1:0][ACC_W-1:0]        i_pe_acc,
  input  logic                                  i_resultReady,
  output logic                                  o_pe_clear,
  output logic                                  o_shift,
  output logic                                  o_busy,
  output logic [N-1:0][N-1:0][DATA_W-1:0]       o_c,
  output logic                                  o_validResult
);

  localparam int CNT_W = (ACCUM_CYCLES > 1) ? $clog2(ACCUM_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCUM_CYCLES - 1);

  state_t                             state_q, state_d;
  logic [CNT_W-1:0]                   cnt_q, cnt_d;
  logic                               valid_q, valid_d;
  logic                               capture;
  logic [N-1:0][N-1:0][DATA_W-1:0]    c_q, c_d;
  logic [N-1:0][N-1:0][DATA_W-1:0]    c_narrow;

  // Sequence state, window counter and result-valid flag.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    capture = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        cnt_d   = CNT_LOAD;
        state_d = ACCUM;
      end
      ACCUM: begin
        if (cnt_q == '0) begin
          state_d = HOLD;
          capture = 1'b1;
          valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      HOLD: begin
        if (i_resultReady) begin
          valid_d = 1'b0;
          state_d = i_start ? CLEAR : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Narrow every PE accumulator in parallel; only used on the capture edge.
  for (genvar r = 0; r < N; r++) begin : g_row
    for (genvar c = 0; c < N; c++) begin : g_col
      assign c_narrow[r][c] = sat8(i_pe_acc[r][c], SATURATE != 0);
    end
  end

  // Result matrix loads only on the final accumulate edge and holds otherwise.
  always_comb begin
    c_d = c_q;
    if (capture) begin
      c_d = c_narrow;
    end
  end

  // Controller and result registers; reset returns everything to idle at once.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      c_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      c_q     <= c_d;
    end
  end

  assign o_pe_clear    = (state_q == CLEAR);
  assign o_shift       = (state_q == ACCUM);
  assign o_busy        = (state_q != IDLE);
  assign o_validResult = valid_q;
  assign o_c           = c_q;

endmodule

// File: tb/tb_systolic_result_collector.sv
// Directed bench for systolic_result_collector: a saturating and a wrapping
// instance share all inputs so both narrowing modes are checked together.
module tb_systolic_result_collector;

  localparam int N  = 4;
  localparam int AW = 18;

  logic i_clk = 1'b0;
  logic i_arst;
  logic i_start;
  logic i_resultReady;
  logic [N-1:0][N-1:0][AW-1:0] i_pe_acc;

  logic o_pe_clear, o_shift, o_busy, o_validResult;
  logic [N-1:0][N-1:0][7:0] o_c;
  logic m_pe_clear, m_shift, m_busy, m_validResult;
  logic [N-1:0][N-1:0][7:0] m_c;

  logic [N-1:0][N-1:0][7:0] exp_c;
  logic [N-1:0][N-1:0][7:0] exp_m;

  int checks = 0;
  int passed = 0;

  systolic_result_collector #(.N(4), .ACC_W(18), .ACCUM_CYCLES(10), .SATURATE(1)) dut (
    .i_clk(i_clk), .i_arst(i_arst), .i_start(i_start), .i_pe_acc(i_pe_acc),
    .i_resultReady(i_resultReady), .o_pe_clear(o_pe_clear), .o_shift(o_shift),
    .o_busy(o_busy), .o_c(o_c), .o_validResult(o_validResult));

  systolic_result_collector #(.N(4), .ACC_W(18), .ACCUM_CYCLES(10), .SATURATE(0)) dut_mod (
    .i_clk(i_clk), .i_arst(i_arst), .i_start(i_start), .i_pe_acc(i_pe_acc),
    .i_resultReady(i_resultReady), .o_pe_clear(m_pe_clear), .o_shift(m_shift),
    .o_busy(m_busy), .o_c(m_c), .o_validResult(m_validResult));

  always #5 i_clk = ~i_clk;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // PE outputs for A = identity: the product equals B, B[i][j] = 4*i+j.
  task automatic set_acc_b();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        i_pe_acc[i][j] = AW'(4 * i + j);
        exp_c[i][j]    = 8'(4 * i + j);
        exp_m[i][j]    = 8'(4 * i + j);
      end
  endtask

  task automatic set_acc_all(input int acc, input int sat_val, input int mod_val);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        i_pe_acc[i][j] = AW'(acc);
        exp_c[i][j]    = 8'(sat_val);
        exp_m[i][j]    = 8'(mod_val);
      end
  endtask

  // Pulse start and advance to the first cycle with the result valid.
  task automatic run_to_valid();
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    repeat (11) step();
  endtask

  task automatic test_reset();
    i_arst = 1'b1; i_start = 1'b0; i_resultReady = 1'b0;
    set_acc_b();
    repeat (2) step();
    checks++; if ({o_pe_clear, o_shift, o_busy, o_validResult} !== 4'b0000)
      $display("[TB] FAIL reset_ctrl got=%b exp=0000", {o_pe_clear, o_shift, o_busy, o_validResult});
      else passed++;
    checks++; if (o_c !== '0) $display("[TB] FAIL reset_c got=%h exp=0", o_c); else passed++;
    i_arst = 1'b0;
    step();
    checks++; if (o_busy !== 1'b0) $display("[TB] FAIL idle_busy got=%b exp=0", o_busy); else passed++;
  endtask

  task automatic test_identity();
    set_acc_b();
    i_resultReady = 1'b1;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    checks++; if ({o_pe_clear, o_shift, o_busy, o_validResult} !== 4'b1010)
      $display("[TB] FAIL id_clear got=%b exp=1010", {o_pe_clear, o_shift, o_busy, o_validResult});
      else passed++;
    for (int k = 0; k < 10; k++) begin
      step();
      checks++; if ({o_pe_clear, o_shift, o_busy, o_validResult} !== 4'b0110)
        $display("[TB] FAIL id_shift_%0d got=%b exp=0110", k, {o_pe_clear, o_shift, o_busy, o_validResult});
        else passed++;
    end
    step();
    checks++; if ({o_pe_clear, o_shift, o_busy, o_validResult} !== 4'b0011)
      $display("[TB] FAIL id_valid got=%b exp=0011", {o_pe_clear, o_shift, o_busy, o_validResult});
      else passed++;
    checks++; if (o_c !== exp_c) $display("[TB] FAIL id_c got=%h exp=%h", o_c, exp_c); else passed++;
    step();
    checks++; if ({o_busy, o_validResult} !== 2'b00)
      $display("[TB] FAIL id_done got=%b exp=00", {o_busy, o_validResult}); else passed++;
    checks++; if (o_c !== exp_c) $display("[TB] FAIL id_c_held got=%h exp=%h", o_c, exp_c); else passed++;
  endtask

  task automatic test_saturation();
    // 4 * 0xFF * 0xFF = 260100; clamps to 255, wraps to 260100 mod 256 = 4.
    set_acc_all(260100, 255, 4);
    i_resultReady = 1'b1;
    run_to_valid();
    checks++; if (o_validResult !== 1'b1) $display("[TB] FAIL sat_valid got=%b exp=1", o_validResult); else passed++;
    checks++; if (o_c !== exp_c) $display("[TB] FAIL sat_c got=%h exp=%h", o_c, exp_c); else passed++;
    checks++; if (m_c !== exp_m) $display("[TB] FAIL mod_c got=%h exp=%h", m_c, exp_m); else passed++;
    step();
  endtask

  task automatic test_stall();
    set_acc_b();
    i_resultReady = 1'b0;
    run_to_valid();
    checks++; if (o_validResult !== 1'b1) $display("[TB] FAIL stall_valid got=%b exp=1", o_validResult); else passed++;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) i_pe_acc[i][j] = AW'(7);
    for (int k = 0; k < 20; k++) begin
      i_start = (k % 3 == 0);
      step();
      checks++; if ({o_pe_clear, o_validResult} !== 2'b01)
        $display("[TB] FAIL stall_%0d clr_valid got=%b exp=01", k, {o_pe_clear, o_validResult}); else passed++;
      checks++; if (o_c !== exp_c) $display("[TB] FAIL stall_c_%0d got=%h exp=%h", k, o_c, exp_c); else passed++;
    end
    i_start = 1'b0;
    i_resultReady = 1'b1;
    step();
    checks++; if ({o_busy, o_validResult} !== 2'b00)
      $display("[TB] FAIL stall_accept got=%b exp=00", {o_busy, o_validResult}); else passed++;
  endtask

  task automatic test_back_to_back();
    set_acc_b();
    i_resultReady = 1'b0;
    run_to_valid();
    checks++; if (o_validResult !== 1'b1) $display("[TB] FAIL b2b_first got=%b exp=1", o_validResult); else passed++;
    // Second product: 300 clamps to 255, wraps to 44.
    set_acc_all(300, 255, 44);
    i_resultReady = 1'b1;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    checks++; if ({o_pe_clear, o_validResult} !== 2'b10)
      $display("[TB] FAIL b2b_restart got=%b exp=10", {o_pe_clear, o_validResult}); else passed++;
    repeat (10) step();
    checks++; if (o_validResult !== 1'b0) $display("[TB] FAIL b2b_early got=%b exp=0", o_validResult); else passed++;
    step();
    checks++; if (o_validResult !== 1'b1) $display("[TB] FAIL b2b_valid got=%b exp=1", o_validResult); else passed++;
    checks++; if (o_c !== exp_c) $display("[TB] FAIL b2b_c got=%h exp=%h", o_c, exp_c); else passed++;
    checks++; if (m_c !== exp_m) $display("[TB] FAIL b2b_mod_c got=%h exp=%h", m_c, exp_m); else passed++;
    step();
  endtask

  task automatic test_start_during_accum();
    int clears;
    int valids;
    set_acc_b();
    i_resultReady = 1'b1;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    clears = int'(o_pe_clear);
    valids = 0;
    for (int k = 0; k < 26; k++) begin
      i_start = (k == 3) || (k == 6);
      step();
      clears += int'(o_pe_clear);
      valids += int'(o_validResult);
    end
    i_start = 1'b0;
    checks++; if (clears !== 1) $display("[TB] FAIL accum_start_clears got=%0d exp=1", clears); else passed++;
    checks++; if (valids !== 1) $display("[TB] FAIL accum_start_valids got=%0d exp=1", valids); else passed++;
    checks++; if (o_c !== exp_c) $display("[TB] FAIL accum_start_c got=%h exp=%h", o_c, exp_c); else passed++;
  endtask

  task automatic test_reset_mid_accum();
    set_acc_b();
    i_resultReady = 1'b1;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    repeat (5) step();
    checks++; if (o_shift !== 1'b1) $display("[TB] FAIL rst_pre_shift got=%b exp=1", o_shift); else passed++;
    i_arst = 1'b1;
    #1;
    checks++; if ({o_pe_clear, o_shift, o_busy, o_validResult} !== 4'b0000)
      $display("[TB] FAIL rst_async_ctrl got=%b exp=0000", {o_pe_clear, o_shift, o_busy, o_validResult});
      else passed++;
    checks++; if (o_c !== '0) $display("[TB] FAIL rst_async_c got=%h exp=0", o_c); else passed++;
    @(posedge i_clk);
    #1;
    i_arst = 1'b0;
    step();
    checks++; if (o_busy !== 1'b0) $display("[TB] FAIL rst_idle got=%b exp=0", o_busy); else passed++;
    set_acc_all(5, 5, 5);
    run_to_valid();
    checks++; if (o_validResult !== 1'b1) $display("[TB] FAIL rst_fresh_valid got=%b exp=1", o_validResult); else passed++;
    checks++; if (o_c !== exp_c) $display("[TB] FAIL rst_fresh_c got=%h exp=%h", o_c, exp_c); else passed++;
    step();
  endtask

  initial begin
    test_reset();
    test_identity();
    test_saturation();
    test_stall();
    test_back_to_back();
    test_start_during_accum();
    test_reset_mid_accum();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
